// File: rtl/barcode_sha_padder.sv
// barcode_sha_padder: packs 16-bit barcode codes into one fully padded SHA-256 block; optional SHA_PAD_DEDUP_EN drops repeats.
// Latency: word 0 valid the cycle after the final accept or flush, then one word per cycle.
// Backpressure: code_ready low for the whole emission; word_out holds while word_ready is low.
module barcode_sha_padder #(
  parameter int CODES = 1
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic [15:0] code_in,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_first,
  output logic        word_last,
  output logic [4:0]  codes_held,
  output logic        dup_drop
);

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] code_buf [0:31];
  logic [4:0]  n;
  logic [4:0]  n_after;
  logic [3:0]  w;
  logic [8:0]  bit_len;
  logic [7:0]  blk [0:63];
  logic        accept, is_dup, store, word_hs;

  assign accept  = code_valid && code_ready;
  assign store   = accept && !is_dup;
  assign n_after = n + {4'b0000, store};
  assign word_hs = word_valid && word_ready;
  assign bit_len = {n, 4'b0000};

`ifdef SHA_PAD_DEDUP_EN
  logic [15:0] last_code;
  logic        last_vld;
  logic        dup_q;

  // Repeat memory survives block boundaries; only reset forgets it.
  assign is_dup   = last_vld && (code_in == last_code);
  assign dup_drop = dup_q;

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      last_code <= '0;
      last_vld  <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      dup_q <= accept && is_dup;
      if (store) begin
        last_code <= code_in;
        last_vld  <= 1'b1;
      end
    end
  end
`else
  assign is_dup   = 1'b0;
  assign dup_drop = 1'b0;
`endif

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if ((store && n_after == 5'(CODES)) || (flush && n_after != 5'd0))
              state_nxt = EMIT;
      EMIT: if (word_hs && w == 4'd15)
              state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    code_ready = (state == FILL);
    word_valid = (state == EMIT);
    word_first = word_valid && (w == 4'd0);
    word_last  = word_valid && (w == 4'd15);
    word_out   = word_valid ? {blk[{w, 2'd0}], blk[{w, 2'd1}], blk[{w, 2'd2}], blk[{w, 2'd3}]}
                            : 32'h0;
    codes_held = n;
  end

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      n <= '0;
      w <= '0;
      for (int i = 0; i < 32; i++) code_buf[i] <= '0;
    end else begin
      if (store) begin
        code_buf[n] <= code_in;
        n           <= n + 5'd1;
      end
      // w wraps to 0 naturally after word 15.
      if (word_hs) begin
        w <= w + 4'd1;
        if (w == 4'd15) n <= '0;
      end
    end
  end

  // Stale buffer entries beyond n are masked by the b < 2n test.
  always_comb begin
    for (int b = 0; b < 64; b++) begin
      blk[6'(b)] = 8'h00;
      if (5'(b / 2) < n)
        blk[6'(b)] = b[0] ? code_buf[5'(b / 2)][7:0] : code_buf[5'(b / 2)][15:8];
      else if (6'(b) == {n, 1'b0})
        blk[6'(b)] = 8'h80;
      else if (b == 62)
        blk[6'(b)] = {7'b0000000, bit_len[8]};
      else if (b == 63)
        blk[6'(b)] = bit_len[7:0];
    end
  end

endmodule

// File: doc/barcode_sha_padder.md
# barcode_sha_padder

Sits between the barcode scanner front end and the SHA-256 core. Collects 16-bit scanned barcode codes over a valid/ready handshake and packs them into one 512-bit SHA-256 message block. The block is fully padded: message bytes, then a 0x80 terminator, zero fill, and a 64-bit big-endian bit length. The block is streamed to the hash core as sixteen 32-bit words over a second valid/ready handshake.

## Interface
- CODES, 1, codes per block before automatic emission; legal range 1..27, so the message is at most 432 bits and fits one block.
- CLK_50M  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- code_in  in  16  barcode code from the scanner stage.
- code_valid  in  1  code_in is valid.
- code_ready  out  1  block can accept a code.
- flush  in  1  pad and emit the held codes now, even if fewer than CODES.
- word_out  out  32  current message-block word, big-endian.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  SHA core accepts word_out.
- word_first  out  1  high with word 0.
- word_last  out  1  high with word 15.
- codes_held  out  5  number of codes stored in the current block (n).
- dup_drop  out  1  one-cycle pulse when a duplicate code is discarded; tied 0 unless SHA_PAD_DEDUP_EN is defined.

## Operation
- Two states: FILL and EMIT. Reset enters FILL.
- Reset values:
  - code_ready=1, word_valid=0, word_first=0, word_last=0.
  - word_out=0, codes_held=0, dup_drop=0.
  - Word index w=0. Code buffer cleared.
- FILL:
  - code_ready=1. An accept is code_valid&&code_ready; it stores code_in at buf[n] and sets n=n+1.
  - Accept that makes n==CODES → EMIT.
  - flush with n>0 → EMIT. flush with n==0 is ignored.
  - flush and code_valid in the same cycle: the code is stored first and included in the block, then → EMIT.
- EMIT:
  - code_ready=0. code_valid and flush are ignored.
  - word_valid=1. word_out = W[w].
  - w advances on word_valid&&word_ready.
  - Handshake on w==15 → FILL with n=0 and w=0.
- Byte b of the 64-byte block, where word w holds bytes 4w..4w+3 big-endian:
  - b<2n: buf[b/2][15:8] if b is even, buf[b/2][7:0] if b is odd.
  - b==2n: 0x80.
  - 56≤b≤63: 64-bit big-endian value 16·n.
  - Otherwise: 0x00.
- Length arithmetic: 16·n is at most 432 and fits in bytes 62-63; bytes 56-61 are always zero.
- word_first = word_valid && w==0. word_last = word_valid && w==15.

## Timing
- Last accept (or flush) at edge k → word_valid=1 from cycle k+1.
- One word per cycle with word_ready held high: 16 cycles per block; code_ready returns to 1 in the cycle after the word-15 handshake.
- While word_valid=1 and word_ready=0, word_out, word_first and word_last hold stable.
- codes_held updates on the accept edge and stays frozen during EMIT.
- Reset asserted mid-operation, including mid-EMIT: outputs go to reset values immediately (asynchronously). The partial block is discarded and never resumed.
- dup_drop is registered: it is high for exactly the cycle after the discarding edge.

## Configuration
- SHA_PAD_DEDUP_EN defined:
  - An accepted code equal to the last stored code is consumed (handshake completes) but not stored.
  - n is unchanged, no EMIT is triggered by that code, and dup_drop pulses.
  - The last-stored code persists across blocks. Reset clears its valid flag, so the first code after reset is never dropped.
  - A simultaneous flush still proceeds if n>0.
- SHA_PAD_DEDUP_EN undefined: every accepted code is stored; dup_drop is constant 0.

## Test plan
- CODES=1, accept 0x1234:
  - W0=0x12348000, W1..W14=0, W15=0x00000010.
  - word_first on W0 only, word_last on W15 only.
- CODES=2, accept 0xAAAA then 0xBBBB:
  - W0=0xAAAABBBB, W1=0x80000000, W15=0x00000020.
  - word_valid rises the cycle after the second accept.
- CODES=4, flush with n=0: no word_valid.
  - Then accept 0x0001 with flush in the same cycle: W0=0x00018000, W15=0x00000010, codes_held=1.
- Backpressure: hold word_ready=0 for 5 cycles at W3.
  - W3 stays on word_out for those cycles.
  - code_valid pulses during EMIT do not change codes_held; code_ready stays 0.
- Reset mid-EMIT at W7:
  - word_valid=0 and codes_held=0 with no clock edge needed.
  - code_ready=1 after release; the next block starts at W0.
- Dedup: accept 0x0042 twice with CODES=2.
  - With SHA_PAD_DEDUP_EN: one dup_drop pulse, codes_held=1, no emission.
  - Without it: codes_held=2, W0=0x00420042.
